fft_delay_commutator: RTL and testbench
=======================================

# fft_delay_commutator

Radix-2 delay-commutator reordering stage for the multi-path-delay-commutator (MDC) pipelined FFT. It accepts two complex sample streams, one pair per enabled cycle, and re-pairs them so that samples DELAY apart are presented together to the next butterfly. The implementation is an input delay line on x1, a 2×2 switch that toggles every DELAY samples, and an output delay line on the upper path. It sits between consecutive butterfly/twiddle stages of the FFT pipeline.

## Interface
- DELAY, 4: commutator depth D in samples (≥1); the switch period is 2·D.
- DATA_WIDTH, 16: width of each of the real and imaginary components.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- enable  in  1  sample-accept strobe. When high, x0/x1 are consumed on the clock edge and the pipeline advances by one sample.
- x0  in  complex_product_t  upper input sample (fields r, i; each signed DATA_WIDTH).
- x1  in  complex_product_t  lower input sample.
- y0  out  complex_product_t  upper output sample, registered.
- y1  out  complex_product_t  lower output sample, registered.
- commutator_out_valid  out  1  y0/y1 hold a valid reordered pair.

## Operation
- Input sample index n counts accepted pairs, i.e. cycles with enable=1, starting at 0 after reset release.
- Internal structure:
  - A DELAY-deep delay line on x1 produces x1d[n] = x1[n−D]; its value is 0 before it fills.
  - Phase counter s = floor(n/D) mod 2.
  - s=0: a=x0, b=x1d. s=1: a=x1d, b=x0.
  - y0 = a delayed by D samples; y1 = b.
- Resulting output stream, for output index m ≥ 0 with p = m mod 2D and base = m − p:
  - p < D: y0[m] = x0[base+p], y1[m] = x0[base+p+D].
  - p ≥ D: y0[m] = x1[base+p−D], y1[m] = x1[base+p].
- r and i are carried unmodified, with no arithmetic and no width change.
- enable=0: delay lines, phase counter, fill counter, outputs and valid all hold their values.
- commutator_out_valid:
  - Set on the edge that produces output m=0.
  - Then stays high until reset; the pipeline is treated as continuously streaming, and trailing zero inputs flush as valid data.
- The phase counter wraps modulo 2D with no gap between blocks. Back-to-back frames are processed seamlessly.

## Timing
- Reset (reset=0, asynchronous): all delay-line registers, the phase counter, the fill counter, y0, y1 and commutator_out_valid clear to 0 immediately.
- Reset asserted mid-stream discards all in-flight data. After release, indexing restarts at n=0 and phase s=0.
- Latency: output index m is registered on the same edge that accepts input n = m+D, so latency is D accepted samples. Stalls (enable=0) stretch latency in cycles but not in samples.
- The first D accepted samples only fill the pipeline; valid stays 0 during them.
- The switch state for sample n is determined by n alone, independent of valid.

## Test plan
- DELAY=4, reset, then x0.r=0..7 and x1.r=8..15 (i=0) on 8 consecutive enabled cycles, followed by zeros:
  - valid rises on the edge accepting input n=4.
  - Over the next 8 outputs, y0.r = 0,1,2,3,8,9,10,11 and y1.r = 4,5,6,7,12,13,14,15.
  - Subsequent outputs are 0 with valid still 1.
- The same stream with enable deasserted for 3 cycles mid-stream: outputs and valid hold during the stall, and the output sequence is identical to the previous case.
- Two back-to-back 8-sample frames (second frame x0.r=16..23, x1.r=24..31): the second frame yields y0.r = 16..19, 24..27 and y1.r = 20..23, 28..31 with no bubble.
- Assert reset at sample 5, release, then replay frame 1:
  - Outputs and valid are 0 during reset.
  - The replay reproduces the first scenario exactly.
- Imaginary path: x0.i = −(n+1) and x1.i = −(n+9) with r=0 are reordered identically to r, including correct sign of negative values.
- DELAY=1, x0.r=1,2 and x1.r=3,4: y0.r = 1,3 and y1.r = 2,4, valid after one accepted sample.

Source files
------------

// File: rtl/fft_delay_commutator_if.sv
// ============================================================================
// fft_delay_commutator_if : complex sample stream bundle for one commutator stage
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_delay_commutator_if #(
  parameter int DATA_WIDTH = 16
);
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] r;
    logic signed [DATA_WIDTH-1:0] i;
  } complex_product_t;

  logic             enable;
  complex_product_t x0;
  complex_product_t x1;
  complex_product_t y0;
  complex_product_t y1;
  logic             commutator_out_valid;

  modport master (
    output enable, x0, x1,
    input  y0, y1, commutator_out_valid
  );

  modport slave (
    input  enable, x0, x1,
    output y0, y1, commutator_out_valid
  );
endinterface

`default_nettype wire

// File: rtl/fft_delay_commutator.sv
// ============================================================================
// fft_delay_commutator : radix-2 MDC delay-commutator re-pairing stage
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_delay_commutator #(
  parameter int DELAY      = 4,
  parameter int DATA_WIDTH = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  fft_delay_commutator_if.slave   cmt
);

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] r;
    logic signed [DATA_WIDTH-1:0] i;
  } complex_t;

  localparam int c_PHASE_W = (DELAY > 1) ? $clog2(2 * DELAY) : 1;
  localparam int c_FILL_W  = (DELAY > 1) ? $clog2(DELAY + 1) : 1;

  localparam logic [c_PHASE_W-1:0] c_PHASE_LAST = c_PHASE_W'(2 * DELAY - 1);
  localparam logic [c_PHASE_W-1:0] c_PHASE_HALF = c_PHASE_W'(DELAY);
  localparam logic [c_FILL_W-1:0]  c_FILL_MAX   = c_FILL_W'(DELAY);

  localparam logic [0:0] c_S_FILL   = 1'b0;
  localparam logic [0:0] c_S_STREAM = 1'b1;

  complex_t w_x0;
  complex_t w_x1;
  complex_t w_x1d;
  complex_t w_a;
  complex_t w_b;
  logic     w_swap;
  logic     w_valid;

  complex_t             r_x1_dl [DELAY];
  complex_t             r_a_dl  [DELAY];
  complex_t             r_y0;
  complex_t             r_y1;
  logic [c_PHASE_W-1:0] r_phase;
  logic [c_FILL_W-1:0]  r_fill;
  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;

  assign w_x0   = cmt.x0;
  assign w_x1   = cmt.x1;
  assign w_x1d  = r_x1_dl[DELAY-1];
  assign w_swap = (r_phase >= c_PHASE_HALF);

  // Second half of each 2*DELAY block crosses the paths
  always_comb begin
    w_a = w_x0;
    w_b = w_x1d;
    if (w_swap) begin
      w_a = w_x1d;
      w_b = w_x0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DELAY; k++) begin
        r_x1_dl[k] <= '0;
        r_a_dl[k]  <= '0;
      end
      r_y0 <= '0;
      r_y1 <= '0;
    end else if (cmt.enable) begin
      r_x1_dl[0] <= w_x1;
      r_a_dl[0]  <= w_a;
      for (int k = 1; k < DELAY; k++) begin
        r_x1_dl[k] <= r_x1_dl[k-1];
        r_a_dl[k]  <= r_a_dl[k-1];
      end
      r_y0 <= r_a_dl[DELAY-1];
      r_y1 <= w_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
      r_fill  <= '0;
    end else if (cmt.enable) begin
      r_phase <= (r_phase == c_PHASE_LAST) ? '0 : r_phase + 1'b1;
      if (r_fill != c_FILL_MAX) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Streaming begins on the edge that accepts sample DELAY (output m=0)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_FILL: begin
        if (cmt.enable && (r_fill == c_FILL_MAX)) begin
          w_state_nxt = c_S_STREAM;
        end
      end
      default: w_state_nxt = c_S_STREAM;
    endcase
  end

  always_comb begin
    w_valid = 1'b0;
    case (r_state)
      c_S_STREAM: w_valid = 1'b1;
      default:    w_valid = 1'b0;
    endcase
  end

  assign cmt.y0                   = r_y0;
  assign cmt.y1                   = r_y1;
  assign cmt.commutator_out_valid = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_fft_delay_commutator.sv
// ============================================================================
// tb_fft_delay_commutator : directed scoreboard bench for DELAY=4 and DELAY=1
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_delay_commutator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_delay_commutator_if #(.DATA_WIDTH(16)) bus4 ();
  fft_delay_commutator_if #(.DATA_WIDTH(16)) bus1 ();

  fft_delay_commutator #(.DELAY(4), .DATA_WIDTH(16)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .cmt   (bus4)
  );

  fft_delay_commutator #(.DELAY(1), .DATA_WIDTH(16)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .cmt   (bus1)
  );

  typedef struct {
    logic [31:0] y0;
    logic [31:0] y1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] h0 [0:63];
  logic [31:0] h1 [0:63];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          n_acc;
  int          cur_d;
  bit          sel;
  logic [31:0] last_y0;
  logic [31:0] last_y1;
  logic        last_v;

  function automatic logic [31:0] obs_y0();
    return sel ? bus1.y0 : bus4.y0;
  endfunction

  function automatic logic [31:0] obs_y1();
    return sel ? bus1.y1 : bus4.y1;
  endfunction

  function automatic logic obs_v();
    return sel ? bus1.commutator_out_valid : bus4.commutator_out_valid;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cre(input int re);
    return {16'(re), 16'h0000};
  endfunction

  function automatic logic [31:0] cim(input int im);
    return {16'h0000, 16'(im)};
  endfunction

  // Drive one cycle; on accept, predict output m = n - D from the stream formula
  task automatic step(input bit en, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   m, p;
    if (sel) begin
      bus1.enable = en; bus1.x0 = a; bus1.x1 = b;
    end else begin
      bus4.enable = en; bus4.x0 = a; bus4.x1 = b;
    end
    if (en) begin
      h0[n_acc] = a;
      h1[n_acc] = b;
      if (n_acc >= cur_d) begin
        m = n_acc - cur_d;
        p = m % (2 * cur_d);
        if (p < cur_d) begin
          e.y0 = h0[m];
          e.y1 = h0[m + cur_d];
        end else begin
          e.y0 = h1[m - cur_d];
          e.y1 = h1[m];
        end
        sb.push_back(e);
      end
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (en && sb.size() > 0) begin
      e       = sb.pop_front();
      last_y0 = e.y0;
      last_y1 = e.y1;
      last_v  = 1'b1;
    end
    check("y0", obs_y0(), last_y0);
    check("y1", obs_y1(), last_y1);
    check("valid", {31'b0, obs_v()}, {31'b0, last_v});
  endtask

  task automatic stall();
    step(1'b0, $urandom, $urandom);
  endtask

  // Reset lands between edges so the clear must be asynchronous
  task automatic do_reset();
    bus4.enable = 1'b0;
    bus1.enable = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_y0_d4", bus4.y0, 32'h0);
    check("rst_y1_d4", bus4.y1, 32'h0);
    check("rst_v_d4", {31'b0, bus4.commutator_out_valid}, 32'h0);
    check("rst_y0_d1", bus1.y0, 32'h0);
    check("rst_v_d1", {31'b0, bus1.commutator_out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_y0", obs_y0(), 32'h0);
    check("rst_hold_v", {31'b0, obs_v()}, 32'h0);
    reset   = 1'b1;
    n_acc   = 0;
    last_y0 = '0;
    last_y1 = '0;
    last_v  = 1'b0;
    sb.delete();
  endtask

  task automatic frame(input int b0, input int b1);
    for (int k = 0; k < 8; k++) step(1'b1, cre(b0 + k), cre(b1 + k));
  endtask

  task automatic zeros(input int cnt);
    for (int k = 0; k < cnt; k++) step(1'b1, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    bus4.enable = 1'b0; bus4.x0 = '0; bus4.x1 = '0;
    bus1.enable = 1'b0; bus1.x0 = '0; bus1.x1 = '0;
    sel = 1'b0; cur_d = 4; n_acc = 0;
    last_y0 = '0; last_y1 = '0; last_v = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // single frame then flush
    frame(0, 8);
    zeros(8);

    // same frame with a three-cycle stall
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, cre(k), cre(8 + k));
    stall(); stall(); stall();
    for (int k = 4; k < 8; k++) step(1'b1, cre(k), cre(8 + k));
    zeros(8);

    // back-to-back frames
    do_reset();
    frame(0, 8);
    frame(16, 24);
    zeros(8);

    // reset mid-stream, then replay
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, cre(k), cre(8 + k));
    do_reset();
    frame(0, 8);
    zeros(8);

    // imaginary path with negative values
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, cim(-(k + 1)), cim(-(k + 9)));
    zeros(8);

    // DELAY = 1 instance
    sel = 1'b1; cur_d = 1;
    do_reset();
    step(1'b1, cre(1), cre(3));
    step(1'b1, cre(2), cre(4));
    zeros(2);
    stall();

    bus1.enable = 1'b0;
    bus4.enable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
